// File: rtl/debug_program_loader_pkg.sv
// Shared definitions for the debug program loader: FSM states and word/byte geometry.
package debug_program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StDone,
    StError
  } state_e;

  localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;
  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned UartWidthDefault = 8;
  localparam int unsigned BytesPerWord = DataWidthDefault / UartWidthDefault;
  localparam int unsigned ByteCntWidth = $clog2(BytesPerWord);
  localparam int unsigned AddrStep = 4;

endpackage

// File: rtl/debug_program_loader_byte_word_packer.sv
// Packs received bytes little-endian into a word; flags the byte that completes it.
module debug_program_loader_byte_word_packer
  import debug_program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       valid,
  input  logic [DATA_WIDTH_UART-1:0] data,
  output logic [DATA_WIDTH-1:0]      word,
  output logic [ByteCntWidth-1:0]    byte_cnt,
  output logic                       word_complete
);

  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [ByteCntWidth-1:0] cnt_q, cnt_d;

  assign word_complete = valid && (cnt_q == ByteCntWidth'(BytesPerWord - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (valid) begin
      shift_d[cnt_q*DATA_WIDTH_UART +: DATA_WIDTH_UART] = data;
      cnt_d = word_complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state view so the completing byte is already part of the word.
  assign word     = shift_d;
  assign byte_cnt = cnt_q;

endmodule

// File: rtl/debug_program_loader.sv
// Assembles UART bytes into instruction words and writes them to instruction memory
// until a HALT word, reporting completion and parity/timeout/overflow errors.
module debug_program_loader
  import debug_program_loader_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          DATA_WIDTH_UART = 8,
  parameter int unsigned          MEM_DEPTH       = 256,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD      = DATA_WIDTH'(HaltWordDefault),
  parameter int unsigned          TIMEOUT_CYCLES  = 100000,
  localparam int unsigned         CountWidth      = $clog2(MEM_DEPTH) + 1
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_byte,
  input  logic                       i_rx_valid,
  input  logic                       i_rx_parity_err,
  input  logic                       i_enable,
  output logic [DATA_WIDTH-1:0]      o_instruccion,
  output logic [DATA_WIDTH-1:0]      o_address,
  output logic                       o_write,
  output logic                       o_loading,
  output logic                       o_done,
  output logic                       o_error,
  output logic [CountWidth-1:0]      o_word_count
);

  localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES) + 1;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic                    done_q, done_d;

  logic                    accept;
  logic                    word_complete;
  logic [DATA_WIDTH-1:0]   packed_word;
  logic [ByteCntWidth-1:0] byte_cnt;
  logic                    timeout_hit;
  logic                    overflow;

  // Bytes are also taken during WRITE so a byte right behind the 4th is not lost.
  assign accept = i_enable && i_rx_valid && !i_rx_parity_err &&
                  (state_q == StCollect || state_q == StWrite);

  debug_program_loader_byte_word_packer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DATA_WIDTH_UART (DATA_WIDTH_UART)
  ) u_packer (
    .clk           (i_clock),
    .reset         (i_reset),
    .clear         (state_q == StIdle),
    .valid         (accept),
    .data          (i_rx_byte),
    .word          (packed_word),
    .byte_cnt      (byte_cnt),
    .word_complete (word_complete)
  );

  // An idle wait is only bounded once a word is partially received.
  assign timeout_hit = (state_q == StCollect) && (byte_cnt != '0) && !i_rx_valid &&
                       (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1));
  assign overflow    = (count_q + 1'b1) == CountWidth'(MEM_DEPTH);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_enable) state_d = StCollect;
      end
      StCollect: begin
        if (!i_enable)                          state_d = StIdle;
        else if (i_rx_valid && i_rx_parity_err) state_d = StError;
        else if (word_complete)                 state_d = StWrite;
        else if (timeout_hit)                   state_d = StError;
      end
      StWrite: begin
        if (!i_enable)                          state_d = StIdle;
        else if (word_q == HALT_WORD)           state_d = StDone;
        else if (overflow)                      state_d = StError;
        else if (i_rx_valid && i_rx_parity_err) state_d = StError;
        else                                    state_d = StCollect;
      end
      StDone, StError: begin
        if (!i_enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    timer_d = '0;
    if (state_q == StCollect && word_complete) word_d = packed_word;
    if (state_q == StWrite) begin
      addr_d  = addr_q + DATA_WIDTH'(AddrStep);
      count_d = count_q + 1'b1;
    end
    if (state_q == StCollect && byte_cnt != '0 && !i_rx_valid) timer_d = timer_q + 1'b1;
    // Leaving for IDLE discards the load so every output reads zero there.
    if (state_d == StIdle) begin
      addr_d  = '0;
      word_d  = '0;
      count_d = '0;
    end
    done_d = (state_d == StDone) && (state_q != StDone);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  assign o_instruccion = word_q;
  assign o_address     = addr_q;
  assign o_write       = (state_q == StWrite);
  assign o_loading     = (state_q == StCollect) || (state_q == StWrite);
  assign o_done        = done_q;
  assign o_error       = (state_q == StError);
  assign o_word_count  = count_q;

endmodule

// File: tb/tb_debug_program_loader.sv
// Randomized bench for debug_program_loader; expected writes come from a byte-stream model.
module tb_debug_program_loader;

  localparam int unsigned MemDepth      = 4;
  localparam int unsigned TimeoutCycles = 16;
  localparam logic [31:0] Halt          = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_par;
  logic        enable;
  logic [31:0] o_instruccion;
  logic [31:0] o_address;
  logic        o_write;
  logic        o_loading;
  logic        o_done;
  logic        o_error;
  logic [2:0]  o_word_count;

  always #5 clk = ~clk;

  debug_program_loader #(
    .MEM_DEPTH      (MemDepth),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_rx_byte       (rx_byte),
    .i_rx_valid      (rx_valid),
    .i_rx_parity_err (rx_par),
    .i_enable        (enable),
    .o_instruccion   (o_instruccion),
    .o_address       (o_address),
    .o_write         (o_write),
    .o_loading       (o_loading),
    .o_done          (o_done),
    .o_error         (o_error),
    .o_word_count    (o_word_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_byte_cyc;

  logic [31:0] wr_data[$];
  logic [31:0] wr_addr[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  logic [7:0]  sent[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  int          exp_end;

  always @(negedge clk) begin
    if (o_write) begin
      wr_data.push_back(o_instruccion);
      wr_addr.push_back(o_address);
      wr_cyc.push_back(cyc);
    end
    if (o_done) done_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par);
    rx_byte       = b;
    rx_valid      = 1'b1;
    rx_par        = par;
    last_byte_cyc = cyc;
    if (!par) sent.push_back(b);
    tick();
    rx_valid = 1'b0;
    rx_par   = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8], 1'b0);
      idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic clear_logs();
    wr_data.delete();
    wr_addr.delete();
    wr_cyc.delete();
    done_cyc.delete();
    sent.delete();
  endtask

  task automatic start_load();
    clear_logs();
    enable = 1'b1;
    tick();
  endtask

  task automatic end_load();
    enable = 1'b0;
    idle(2);
  endtask

  // Reference: group the accepted byte stream into little-endian words; each word is
  // written at 4*index; a HALT word ends with DONE, the MEM_DEPTH-th word with ERROR.
  task automatic model_load();
    logic [31:0] w;
    exp_data.delete();
    exp_addr.delete();
    exp_end = 0;
    for (int i = 0; i + 3 < sent.size(); i += 4) begin
      w = {sent[i+3], sent[i+2], sent[i+1], sent[i]};
      exp_data.push_back(w);
      exp_addr.push_back(32'(i));
      if (w == Halt) begin
        exp_end = 1;
        break;
      end
      if (exp_data.size() == MemDepth) begin
        exp_end = 2;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_non_halt();
    logic [31:0] w;
    w = $urandom;
    if (w == Halt) w = 32'h0;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    rx_valid = 1'b0;
    rx_par = 1'b0;
    rx_byte = 8'h00;
    idle(3);
    @(negedge clk);
    checks++;
    if ({o_write, o_loading, o_done, o_error, o_word_count, o_address, o_instruccion} !== '0)
    begin
      failures++;
      $display("FAIL reset_outputs: got w=%b l=%b d=%b e=%b n=%0d a=%h i=%h expected all 0",
               o_write, o_loading, o_done, o_error, o_word_count, o_address, o_instruccion);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    checks++;
    if ({o_write, o_loading, o_error, o_word_count} !== '0 || wr_data.size() != 0) begin
      failures++;
      $display("FAIL reset_held: got w=%b l=%b e=%b writes=%0d expected all 0",
               o_write, o_loading, o_error, wr_data.size());
    end
    rst = 1'b0;
    enable = 1'b0;
    idle(2);
  endtask

  task automatic test_normal_load();
    int cyc4;
    logic [7:0] first [4] = '{8'h00, 8'h00, 8'h22, 8'h20};
    start_load();
    for (int i = 0; i < 4; i++) begin
      send_byte(first[i], 1'b0);
      if (i == 3) cyc4 = last_byte_cyc;
      idle(int'($urandom_range(0, 3)));
    end
    send_word(Halt, 3);
    idle(4);
    model_load();
    checks++;
    if (wr_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL normal_writes: got %0d expected %0d", wr_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== exp_data[i] || wr_addr[i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL normal_word%0d: got %h@%h expected %h@%h",
                 i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    checks++;
    if (wr_data.size() == 0 || wr_data[0] !== 32'h2022_0000) begin
      failures++;
      $display("FAIL normal_first_word: got %h expected 20220000",
               wr_data.size() ? wr_data[0] : 32'hx);
    end
    checks++;
    if (wr_cyc.size() == 0 || wr_cyc[0] != cyc4 + 1) begin
      failures++;
      $display("FAIL normal_latency: got cycle %0d expected %0d",
               wr_cyc.size() ? wr_cyc[0] : -1, cyc4 + 1);
    end
    checks++;
    if (done_cyc.size() != 1 || wr_cyc.size() != 2 || done_cyc[0] != wr_cyc[1] + 1) begin
      failures++;
      $display("FAIL normal_done: got %0d pulses at %0d expected 1 pulse after write",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
    checks++;
    if (o_word_count !== 3'(exp_data.size()) || o_loading !== 1'b0 || o_error !== 1'b0) begin
      failures++;
      $display("FAIL normal_status: got n=%0d l=%b e=%b expected n=%0d l=0 e=0",
               o_word_count, o_loading, o_error, exp_data.size());
    end
    end_load();
    checks++;
    if ({o_loading, o_done, o_error, o_word_count, o_address, o_instruccion} !== '0) begin
      failures++;
      $display("FAIL normal_idle: got n=%0d a=%h i=%h expected 0",
               o_word_count, o_address, o_instruccion);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    int b5;
    for (int it = 0; it < 3; it++) begin
      start_load();
      w0 = rand_non_halt();
      w1 = (it == 2) ? Halt : $urandom;
      for (int i = 0; i < 8; i++) begin
        send_byte((i < 4) ? w0[i*8 +: 8] : w1[(i-4)*8 +: 8], 1'b0);
        if (i == 4) b5 = last_byte_cyc;
      end
      idle(3);
      model_load();
      checks++;
      if (wr_data.size() != exp_data.size()) begin
        failures++;
        $display("FAIL b2b_writes: got %0d expected %0d", wr_data.size(), exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
        checks++;
        if (wr_data[i] !== exp_data[i] || wr_addr[i] !== exp_addr[i]) begin
          failures++;
          $display("FAIL b2b_word%0d: got %h@%h expected %h@%h",
                   i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
        end
      end
      checks++;
      if (wr_cyc.size() == 0 || wr_cyc[0] != b5) begin
        failures++;
        $display("FAIL b2b_overlap: write cycle %0d expected %0d",
                 wr_cyc.size() ? wr_cyc[0] : -1, b5);
      end
      checks++;
      if (o_word_count !== 3'(exp_data.size()) || o_loading !== (exp_end == 0)) begin
        failures++;
        $display("FAIL b2b_status: got n=%0d l=%b expected n=%0d l=%b",
                 o_word_count, o_loading, exp_data.size(), exp_end == 0);
      end
      end_load();
    end
  endtask

  task automatic test_parity();
    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b1);
    checks++;
    if (o_error !== 1'b1 || o_loading !== 1'b0) begin
      failures++;
      $display("FAIL parity_error: got e=%b l=%b expected e=1 l=0", o_error, o_loading);
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    idle(3);
    checks++;
    if (wr_data.size() != 0 || o_error !== 1'b1) begin
      failures++;
      $display("FAIL parity_nowrite: got writes=%0d e=%b expected 0 writes e=1",
               wr_data.size(), o_error);
    end
    end_load();
    checks++;
    if ({o_write, o_loading, o_done, o_error, o_word_count, o_address, o_instruccion} !== '0)
    begin
      failures++;
      $display("FAIL parity_idle: got e=%b n=%0d a=%h expected 0",
               o_error, o_word_count, o_address);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    w = rand_non_halt();
    w[31:24] = 8'($urandom_range(0, 254));
    start_load();
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    idle(15);
    checks++;
    if (o_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_gap15: got e=%b expected 0", o_error);
    end
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], 1'b0);
    idle(40);
    model_load();
    checks++;
    if (wr_data.size() != 1 || wr_data[0] !== exp_data[0] || wr_addr[0] !== exp_addr[0]) begin
      failures++;
      $display("FAIL timeout_word: got %0d writes expected %h@%h",
               wr_data.size(), exp_data[0], exp_addr[0]);
    end
    checks++;
    if (o_error !== 1'b0 || o_loading !== 1'b1) begin
      failures++;
      $display("FAIL timeout_unbounded: got e=%b l=%b expected e=0 l=1", o_error, o_loading);
    end
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    idle(15);
    checks++;
    if (o_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got e=%b expected 0", o_error);
    end
    tick();
    checks++;
    if (o_error !== 1'b1 || o_loading !== 1'b0) begin
      failures++;
      $display("FAIL timeout_expire: got e=%b l=%b expected e=1 l=0", o_error, o_loading);
    end
    idle(3);
    checks++;
    if (wr_data.size() != 1) begin
      failures++;
      $display("FAIL timeout_nowrite: got %0d writes expected 1", wr_data.size());
    end
    end_load();
  endtask

  task automatic test_overflow();
    start_load();
    for (int i = 0; i < 5; i++) send_word(rand_non_halt(), 2);
    idle(3);
    model_load();
    checks++;
    if (wr_data.size() != exp_data.size()) begin
      failures++;
      $display("FAIL overflow_writes: got %0d expected %0d", wr_data.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== exp_data[i] || wr_addr[i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL overflow_word%0d: got %h@%h expected %h@%h",
                 i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    checks++;
    if (wr_addr.size() != 4 || wr_addr[3] !== 32'hC) begin
      failures++;
      $display("FAIL overflow_last_addr: got %0d writes expected 4 ending at 0000000c",
               wr_addr.size());
    end
    checks++;
    if (o_error !== (exp_end == 2) || o_word_count !== 3'(exp_data.size())) begin
      failures++;
      $display("FAIL overflow_status: got e=%b n=%0d expected e=%b n=%0d",
               o_error, o_word_count, exp_end == 2, exp_data.size());
    end
    end_load();
  endtask

  task automatic test_abort_reset();
    logic [31:0] w;
    start_load();
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    enable = 1'b0;
    tick();
    checks++;
    if (o_loading !== 1'b0 || o_word_count !== 3'd0) begin
      failures++;
      $display("FAIL abort_idle: got l=%b n=%0d expected 0", o_loading, o_word_count);
    end
    idle(2);
    checks++;
    if (wr_data.size() != 0) begin
      failures++;
      $display("FAIL abort_nowrite: got %0d writes expected 0", wr_data.size());
    end

    start_load();
    send_word(Halt, 2);
    idle(3);
    model_load();
    checks++;
    if (wr_data.size() != 1 || wr_data[0] !== exp_data[0] || wr_addr[0] !== exp_addr[0] ||
        done_cyc.size() != 1 || o_word_count !== 3'd1) begin
      failures++;
      $display("FAIL reload_halt: got %0d writes %0d done n=%0d expected %h@%h",
               wr_data.size(), done_cyc.size(), o_word_count, exp_data[0], exp_addr[0]);
    end
    end_load();

    start_load();
    w = rand_non_halt();
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b0);
    enable = 1'b0;
    tick();
    checks++;
    if (wr_data.size() != 1 || wr_data[0] !== w || wr_addr[0] !== 32'h0 ||
        o_loading !== 1'b0 || o_word_count !== 3'd0) begin
      failures++;
      $display("FAIL abort_in_write: got %0d writes l=%b n=%0d expected 1 write %h@0",
               wr_data.size(), o_loading, o_word_count, w);
    end
    idle(2);

    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    rx_byte  = 8'($urandom);
    rx_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_write, o_loading, o_done, o_error, o_word_count, o_address, o_instruccion} !== '0)
    begin
      failures++;
      $display("FAIL reset_midword: got w=%b l=%b n=%0d i=%h expected all 0",
               o_write, o_loading, o_word_count, o_instruccion);
    end
    rst    = 1'b0;
    enable = 1'b0;
    idle(3);
    checks++;
    if (wr_data.size() != 0) begin
      failures++;
      $display("FAIL reset_nowrite: got %0d writes expected 0", wr_data.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    rx_valid = 1'b0;
    rx_par   = 1'b0;
    rx_byte  = 8'h00;
    test_reset();
    test_normal_load();
    test_back_to_back();
    test_parity();
    test_timeout();
    test_overflow();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
